// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared command codes, FSM encoding and counter width for counter_sequencer
package counter_seq_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_LOAD = 2'b01, OP_UP = 2'b10, OP_DOWN = 2'b11} op_e;
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_CLR = 3'd1, S_LD = 3'd2, S_RUN = 3'd3, S_DONE = 3'd4} state_e;
endpackage

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: mirrors the external counter from the issued controls and flags a sticky divergence
module counter_seq_checker
  import counter_seq_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             cntClear,
  input  logic             cntLoad,
  input  logic             cntEnable,
  input  logic             cntIncOrDec,
  input  logic [CNT_W-1:0] cntInput,
  input  logic [CNT_W-1:0] cntValue,
  output logic             mismatch
);
  logic [CNT_W-1:0] r_mirror;
  logic             r_armed;
  logic             r_mismatch;
  assign mismatch = r_mismatch;
  always_ff @(posedge clock) begin
    if (clear) begin
      r_mirror   <= '0;
      r_armed    <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_mirror   <= cntClear ? '0 : cntLoad ? cntInput :
                    cntEnable ? (cntIncOrDec ? r_mirror + 1'b1 : r_mirror - 1'b1) : r_mirror;
      r_armed    <= r_armed | cntClear | cntLoad;
      r_mismatch <= r_mismatch | (r_armed && cntValue != r_mirror);
    end
  end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command FSM driving an external up/down counter with registered controls.
// Define COUNTER_SEQ_CHECK_EN to add the mirror checker and the sticky mismatch output.
module counter_sequencer
  import counter_seq_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [1:0]       cmdOp,
  input  logic [CNT_W-1:0] cmdData,
  output logic [CNT_W-1:0] cntInput,
  output logic             cntClear,
  output logic             cntLoad,
  output logic             cntIncOrDec,
  output logic             cntEnable,
  input  logic [CNT_W-1:0] cntValue,
  output logic             done,
  output logic             busy
`ifdef COUNTER_SEQ_CHECK_EN
  ,
  output logic             mismatch
`endif
);
  state_e           r_state, w_state;
  logic [CNT_W-1:0] r_step, w_step, r_cntInput, w_cntInput;
  logic             r_clr, w_clr, r_ld, w_ld, r_en, w_en, r_dir, w_dir, r_done, w_done, r_busy, r_ready;
  assign cmdReady    = r_ready;
  assign cntInput    = r_cntInput;
  assign cntClear    = r_clr;
  assign cntLoad     = r_ld;
  assign cntEnable   = r_en;
  assign cntIncOrDec = r_dir;
  assign done        = r_done;
  assign busy        = r_busy;
  always_comb begin
    w_state    = r_state;
    w_step     = r_step;
    w_cntInput = r_cntInput;
    w_dir      = r_dir;
    w_clr      = 1'b0;
    w_ld       = 1'b0;
    w_en       = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: if (cmdValid) begin
        case (cmdOp)
          OP_CLEAR: begin
            w_state = S_CLR;
            w_clr   = 1'b1;
          end
          OP_LOAD: begin
            w_state    = S_LD;
            w_ld       = 1'b1;
            w_cntInput = cmdData;
          end
          default: begin
            w_state = (cmdData == '0) ? S_DONE : S_RUN;
            w_done  = (cmdData == '0);
            w_en    = (cmdData != '0);
            w_step  = (cmdData != '0) ? cmdData : r_step;
            w_dir   = (cmdData != '0) ? ~cmdOp[0] : r_dir;
          end
        endcase
      end
      S_CLR, S_LD: begin
        w_state = S_DONE;
        w_done  = 1'b1;
      end
      S_RUN: begin
        // the step counter holds the cycles of enable still owed, including the current one
        w_state = (r_step == 8'd1) ? S_DONE : S_RUN;
        w_done  = (r_step == 8'd1);
        w_en    = (r_step != 8'd1);
        w_step  = (r_step == 8'd1) ? r_step : r_step - 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_cntInput <= '0;
      r_clr      <= 1'b0;
      r_ld       <= 1'b0;
      r_en       <= 1'b0;
      r_dir      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_step     <= w_step;
      r_cntInput <= w_cntInput;
      r_clr      <= w_clr;
      r_ld       <= w_ld;
      r_en       <= w_en;
      r_dir      <= w_dir;
      r_done     <= w_done;
      r_busy     <= (w_state != S_IDLE);
      r_ready    <= (w_state == S_IDLE);
    end
  end
`ifdef COUNTER_SEQ_CHECK_EN
  counter_seq_checker u_checker (
    .clock      (clock),
    .clear      (clear),
    .cntClear   (r_clr),
    .cntLoad    (r_ld),
    .cntEnable  (r_en),
    .cntIncOrDec(r_dir),
    .cntInput   (r_cntInput),
    .cntValue   (cntValue),
    .mismatch   (mismatch)
  );
`else
  logic w_unused;
  assign w_unused = ^cntValue;
`endif
endmodule
